// File: rtl/fpu_norm_round_pack_if.sv
// FPU output-stage bus: unified-format beat in, packed FP16 beat out.
// master drives the input beat and dout_ready; slave is the pack stage.
interface fpu_norm_round_pack_if #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 22
);
  logic             din_valid;
  logic             din_ready;
  logic             din_uni_y_sgn;
  logic [EXP_W-1:0] din_uni_y_exp;
  logic [MAN_W-1:0] din_uni_y_man_dn;
  logic             dout_valid;
  logic             dout_ready;
  logic [15:0]      dout_fp16;
  logic             dout_ovf;
  logic             dout_unf;
  logic             dout_inexact;

  modport master (
    output din_valid, din_uni_y_sgn, din_uni_y_exp,
    output din_uni_y_man_dn, dout_ready,
    input  din_ready, dout_valid, dout_fp16,
    input  dout_ovf, dout_unf, dout_inexact
  );

  modport slave (
    input  din_valid, din_uni_y_sgn, din_uni_y_exp,
    input  din_uni_y_man_dn, dout_ready,
    output din_ready, dout_valid, dout_fp16,
    output dout_ovf, dout_unf, dout_inexact
  );
endinterface

// File: rtl/fpu_norm_round_pack.sv
// FPU output stage: normalize, round-to-nearest-even, pack to FP16.
// Three-stage pipeline that stalls as a whole under backpressure.
module fpu_norm_round_pack #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 22,
  parameter int BIAS  = 15
) (
  input  logic clk,
  input  logic rst,
  fpu_norm_round_pack_if.slave bus
);
  localparam int FW = MAN_W - 2;
  localparam logic [7:0] EMAX = 8'(2 * BIAS + 1);

  logic adv;

  logic            s1_valid_q, s1_sgn_q, s1_zero_q, s1_rsh_q;
  logic [4:0]      s1_lz_q;
  logic [7:0]      s1_e_q;
  logic [MAN_W-1:0] s1_man_q;

  logic            s2_valid_q, s2_sgn_q, s2_zero_q, s2_sob_q;
  logic [7:0]      s2_e_q;
  logic [FW:0]     s2_m_q;

  logic            s3_valid_q, s3_ovf_q, s3_unf_q, s3_inx_q;
  logic [15:0]     s3_fp16_q;

  assign adv           = ~s3_valid_q | bus.dout_ready;
  assign bus.din_ready = adv;

  logic [7:0] e_in, lim, lz_w;
  logic [4:0] p, lz_d;
  logic [7:0] e1_d;

  // Leading-one detect and exponent adjustment for the incoming beat
  always_comb begin
    e_in = (bus.din_uni_y_exp == '0) ? 8'd1 : 8'(bus.din_uni_y_exp);
    p = '0;
    for (int i = 0; i <= FW; i++) begin
      if (bus.din_uni_y_man_dn[i]) p = 5'(i);
    end
    lim  = e_in - 8'd1;
    lz_w = 8'(5'(FW) - p);
    lz_d = (lz_w > lim) ? lim[4:0] : lz_w[4:0];
    e1_d = bus.din_uni_y_man_dn[MAN_W-1] ? e_in + 8'd1
                                         : e_in - 8'(lz_d);
  end

  // Stage 1: capture detect results
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= bus.din_valid;
      s1_sgn_q   <= bus.din_uni_y_sgn;
      s1_zero_q  <= (bus.din_uni_y_man_dn == '0);
      s1_rsh_q   <= bus.din_uni_y_man_dn[MAN_W-1];
      s1_lz_q    <= lz_d;
      s1_e_q     <= e1_d;
      s1_man_q   <= bus.din_uni_y_man_dn;
    end
  end

  logic [FW:0] m2_d;

  // Normalizing shift; a right shift keeps the dropped bit for sticky
  always_comb begin
    m2_d = s1_rsh_q ? (FW+1)'(s1_man_q >> 1)
                    : (FW+1)'(s1_man_q << s1_lz_q);
  end

  // Stage 2: capture shifted mantissa
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sgn_q   <= s1_sgn_q;
      s2_zero_q  <= s1_zero_q;
      s2_sob_q   <= s1_rsh_q & s1_man_q[0];
      s2_e_q     <= s1_e_q;
      s2_m_q     <= m2_d;
    end
  end

  logic        g, st, rup, hid, inx;
  logic [11:0] sum;
  logic [7:0]  eo;
  logic [9:0]  fr;
  logic [15:0] fp16_d;
  logic        ovf_d, unf_d, inx_d;

  // Round to nearest-even and pack into FP16 with flags
  always_comb begin
    g      = s2_m_q[FW-11];
    st     = (|s2_m_q[FW-12:0]) | s2_sob_q;
    rup    = g & (st | s2_m_q[FW-10]);
    sum    = {1'b0, s2_m_q[FW:FW-10]} + 12'(rup);
    hid    = sum[11] | sum[10];
    eo     = s2_e_q + 8'(sum[11]);
    fr     = sum[11] ? 10'h0 : sum[9:0];
    inx    = g | st;
    fp16_d = {s2_sgn_q, 5'h0, fr};
    ovf_d  = 1'b0;
    inx_d  = inx;
    unf_d  = inx;
    if (s2_zero_q) begin
      fp16_d = {s2_sgn_q, 15'h0};
      inx_d  = 1'b0;
      unf_d  = 1'b0;
    end else if (hid && eo >= EMAX) begin
      fp16_d = {s2_sgn_q, 5'h1F, 10'h0};
      ovf_d  = 1'b1;
      inx_d  = 1'b1;
      unf_d  = 1'b0;
    end else if (hid) begin
      fp16_d = {s2_sgn_q, eo[4:0], fr};
      unf_d  = 1'b0;
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_fp16_q  <= 16'h0;
      s3_ovf_q   <= 1'b0;
      s3_unf_q   <= 1'b0;
      s3_inx_q   <= 1'b0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      s3_fp16_q  <= fp16_d;
      s3_ovf_q   <= ovf_d;
      s3_unf_q   <= unf_d;
      s3_inx_q   <= inx_d;
    end
  end

  assign bus.dout_valid   = s3_valid_q;
  assign bus.dout_fp16    = s3_fp16_q;
  assign bus.dout_ovf     = s3_ovf_q;
  assign bus.dout_unf     = s3_unf_q;
  assign bus.dout_inexact = s3_inx_q;
endmodule

// File: tb/tb_fpu_norm_round_pack.sv
// Bench for fpu_norm_round_pack: directed plan cases plus random
// traffic against an exact-arithmetic FP16 reference model.
module tb_fpu_norm_round_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_norm_round_pack_if bus ();

  fpu_norm_round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;
  int outs = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [18:0] obs();
    return {bus.dout_ovf, bus.dout_unf, bus.dout_inexact, bus.dout_fp16};
  endfunction

  // value = m * 2^(max(e,1)-35); work in integer units of 2^-34
  function automatic logic [18:0] ref_model(input logic s,
      input logic [5:0] e, input logic [21:0] m);
    logic [127:0] x, r, rem, half;
    int t, q, be, sh;
    logic inx;
    if (m == 22'h0) return {3'b000, s, 15'h0};
    sh = (e == 6'd0) ? 0 : int'(e) - 1;
    x = 128'(m) << sh;
    t = 0;
    for (int i = 0; i < 128; i++) if (x[i]) t = i;
    q = (t - 10 > 10) ? t - 10 : 10;
    r = x >> q;
    rem = x - (r << q);
    half = 128'(1) << (q - 1);
    inx = (rem != 0);
    if (rem > half || (rem == half && r[0])) r = r + 1;
    if (r >= 2048) begin
      r = r >> 1;
      q++;
    end
    if (r < 1024) return {1'b0, inx, inx, s, 5'd0, r[9:0]};
    be = q - 9;
    if (be >= 31) return {3'b101, s, 5'h1F, 10'h0};
    return {2'b00, inx, s, be[4:0], r[9:0]};
  endfunction

  task automatic step(input logic v, input logic s, input logic [5:0] e,
                      input logic [21:0] m, input logic rdy,
                      output logic acc);
    @(negedge clk);
    bus.din_valid = v;
    bus.din_uni_y_sgn = s;
    bus.din_uni_y_exp = e;
    bus.din_uni_y_man_dn = m;
    bus.dout_ready = rdy;
    #1;
    acc = v & bus.din_ready;
    if (!rst) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("stray", 32'd1, 32'd0);
        end else begin
          chk(rdy ? "out" : "held", 32'(obs()), 32'(exp_q[0]));
          if (rdy) begin
            void'(exp_q.pop_front());
            outs++;
          end
        end
      end
      if (acc) exp_q.push_back(ref_model(s, e, m));
    end
  endtask

  task automatic one(input string tag, input logic s, input logic [5:0] e,
                     input logic [21:0] m, input logic [18:0] want);
    int n;
    @(negedge clk);
    bus.din_valid = 1'b1;
    bus.din_uni_y_sgn = s;
    bus.din_uni_y_exp = e;
    bus.din_uni_y_man_dn = m;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    n = 1;
    while (!bus.dout_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk(tag, 32'(obs()), 32'(want));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  logic acc;
  logic saw_stall;
  int pend;

  initial begin
    bus.din_valid = 1'b0;
    bus.din_uni_y_sgn = 1'b0;
    bus.din_uni_y_exp = '0;
    bus.din_uni_y_man_dn = '0;
    bus.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_out", 32'(obs()), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_din_ready", 32'(bus.din_ready), 32'd1);

    one("one",      1'b0, 6'd15, 22'h100000, {3'b000, 16'h3C00});
    one("three",    1'b0, 6'd15, 22'h300000, {3'b000, 16'h4200});
    one("mthree",   1'b1, 6'd15, 22'h300000, {3'b000, 16'hC200});
    one("tie_even", 1'b0, 6'd15, 22'h100200, {3'b001, 16'h3C00});
    one("tie_up",   1'b0, 6'd15, 22'h100600, {3'b001, 16'h3C02});
    one("above",    1'b0, 6'd15, 22'h100201, {3'b001, 16'h3C01});
    one("ovf",      1'b0, 6'd31, 22'h100000, {3'b101, 16'h7C00});
    one("ovf_rnd",  1'b0, 6'd30, 22'h1FFE00, {3'b101, 16'h7C00});
    one("sub5",     1'b0, 6'd5,  22'h000400, {3'b000, 16'h0010});
    one("sub1",     1'b0, 6'd1,  22'h080000, {3'b000, 16'h0200});
    one("nzero",    1'b1, 6'd0,  22'h000000, {3'b000, 16'h8000});
    one("tiny",     1'b0, 6'd1,  22'h000001, {3'b011, 16'h0000});

    // back-to-back burst of 4 with dout_ready low in cycles 3-5
    exp_q.delete();
    outs = 0;
    saw_stall = 1'b0;
    pend = 0;
    for (int c = 1; c <= 20; c++) begin
      step(pend < 4, pend[0], 6'(14 + pend), 22'h100000 + 22'(pend * 22'h1234),
           !(c >= 3 && c <= 5), acc);
      if (pend < 4 && !bus.din_ready) saw_stall = 1'b1;
      if (acc) pend++;
    end
    chk("bp_stall", 32'(saw_stall), 32'd1);
    chk("bp_count", 32'(outs), 32'd4);
    chk("bp_left", 32'(exp_q.size()), 32'd0);

    // second burst, reset lands in its second cycle
    step(1'b1, 1'b0, 6'd15, 22'h200000, 1'b0, acc);
    step(1'b1, 1'b1, 6'd16, 22'h240000, 1'b0, acc);
    rst = 1'b1;
    step(1'b0, 1'b0, 6'd0, 22'h0, 1'b1, acc);
    chk("rst_mid_valid", 32'(bus.dout_valid), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 6'd0, 22'h0, 1'b1, acc);
      chk("post_rst_valid", 32'(bus.dout_valid), 32'd0);
    end

    // random traffic with random backpressure
    do_reset();
    outs = 0;
    pend = 0;
    for (int i = 0; i < 600; i++) begin
      logic [21:0] m;
      logic [5:0]  e;
      m = 22'($urandom) >> $urandom_range(0, 22);
      e = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63))
                                      : 6'($urandom_range(8, 22));
      step($urandom_range(0, 3) != 0, 1'($urandom), e, m,
           $urandom_range(0, 3) != 0, acc);
      if (acc) pend++;
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      step(1'b0, 1'b0, 6'd0, 22'h0, 1'b1, acc);
    chk("rnd_drain", 32'(exp_q.size()), 32'd0);
    chk("rnd_count", 32'(outs), 32'(pend));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
